// File: rtl/reg_file.sv
// Architectural register file with rename tracking for an out-of-order core.
// Each register holds a committed value, a busy flag and the ROB tag of its
// pending producer. Source queries are combinational and bypass a commit
// arriving in the same cycle whose tag matches the pending producer.
module reg_file #(
  parameter int ROB_LOG = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               flush,
  input  logic               commit_en,
  input  logic [4:0]         commit_index,
  input  logic [ROB_LOG-1:0] commit_robid,
  input  logic [31:0]        commit_value,
  input  logic               issue_en,
  input  logic [4:0]         issue_dest,
  input  logic [ROB_LOG-1:0] issue_robid,
  input  logic [4:0]         rs1_index,
  input  logic [4:0]         rs2_index,
  output logic [31:0]        rs1_value,
  output logic [31:0]        rs2_value,
  output logic               rs1_busy,
  output logic               rs2_busy,
  output logic [ROB_LOG-1:0] rs1_robid,
  output logic [ROB_LOG-1:0] rs2_robid
);

  logic [31:0]        value_q [32];
  logic               busy_q  [32];
  logic [ROB_LOG-1:0] tag_q   [32];

  logic commit_nz;
  logic issue_nz;

  assign commit_nz = commit_en && (commit_index != 5'd0);
  assign issue_nz  = issue_en && (issue_dest != 5'd0) && !flush;

  // State update: reset wins over everything, rdy low freezes all state.
  // Issue is evaluated after commit so a same-register issue keeps busy set.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        value_q[i] <= '0;
        busy_q[i]  <= 1'b0;
        tag_q[i]   <= '0;
      end
    end else if (rdy) begin
      for (int i = 1; i < 32; i++) begin
        if (commit_nz && (commit_index == 5'(i))) begin
          value_q[i] <= commit_value;
        end
        if (flush) begin
          busy_q[i] <= 1'b0;
        end else if (issue_nz && (issue_dest == 5'(i))) begin
          busy_q[i] <= 1'b1;
          tag_q[i]  <= issue_robid;
        end else if (commit_nz && (commit_index == 5'(i)) && busy_q[i] &&
                     (tag_q[i] == commit_robid)) begin
          busy_q[i] <= 1'b0;
        end
      end
    end
  end

  // Source port 1 lookup with same-cycle commit bypass.
  always_comb begin
    rs1_value = '0;
    rs1_busy  = 1'b0;
    rs1_robid = '0;
    if (rs1_index != 5'd0) begin
      if (!busy_q[rs1_index]) begin
        rs1_value = value_q[rs1_index];
      end else if (commit_en && (commit_index == rs1_index) &&
                   (commit_robid == tag_q[rs1_index])) begin
        rs1_value = commit_value;
      end else begin
        rs1_value = value_q[rs1_index];
        rs1_busy  = 1'b1;
        rs1_robid = tag_q[rs1_index];
      end
    end
  end

  // Source port 2 lookup with same-cycle commit bypass.
  always_comb begin
    rs2_value = '0;
    rs2_busy  = 1'b0;
    rs2_robid = '0;
    if (rs2_index != 5'd0) begin
      if (!busy_q[rs2_index]) begin
        rs2_value = value_q[rs2_index];
      end else if (commit_en && (commit_index == rs2_index) &&
                   (commit_robid == tag_q[rs2_index])) begin
        rs2_value = commit_value;
      end else begin
        rs2_value = value_q[rs2_index];
        rs2_busy  = 1'b1;
        rs2_robid = tag_q[rs2_index];
      end
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: rename, commit, bypass, flush, x0 and freeze.
module tb_reg_file;

  localparam int ROB_LOG = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               rdy;
  logic               flush;
  logic               commit_en;
  logic [4:0]         commit_index;
  logic [ROB_LOG-1:0] commit_robid;
  logic [31:0]        commit_value;
  logic               issue_en;
  logic [4:0]         issue_dest;
  logic [ROB_LOG-1:0] issue_robid;
  logic [4:0]         rs1_index;
  logic [4:0]         rs2_index;
  logic [31:0]        rs1_value;
  logic [31:0]        rs2_value;
  logic               rs1_busy;
  logic               rs2_busy;
  logic [ROB_LOG-1:0] rs1_robid;
  logic [ROB_LOG-1:0] rs2_robid;

  int passed = 0;
  int total  = 0;

  reg_file #(.ROB_LOG(ROB_LOG)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .commit_en(commit_en), .commit_index(commit_index),
    .commit_robid(commit_robid), .commit_value(commit_value),
    .issue_en(issue_en), .issue_dest(issue_dest), .issue_robid(issue_robid),
    .rs1_index(rs1_index), .rs2_index(rs2_index),
    .rs1_value(rs1_value), .rs2_value(rs2_value),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rs1_robid(rs1_robid), .rs2_robid(rs2_robid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; commit_en = 0; issue_en = 0;
    commit_index = 0; commit_robid = 0; commit_value = 0;
    issue_dest = 0; issue_robid = 0;
  endtask

  task automatic issue(input logic [4:0] d, input logic [ROB_LOG-1:0] t);
    issue_en = 1; issue_dest = d; issue_robid = t;
    tick();
    issue_en = 0;
  endtask

  initial begin
    rst = 1; rdy = 0; rs1_index = 5; rs2_index = 0;
    idle();
    tick();
    rst = 0; rdy = 1;
    #1;
    chk("reset_r5_val", rs1_value, 32'h0);
    chk("reset_r5_busy", {31'b0, rs1_busy}, 32'h0);
    chk("reset_r0_val", rs2_value, 32'h0);

    // rename r5 -> rob3, then bypass its commit
    issue(5, 3);
    rs1_index = 5; #1;
    chk("r5_busy", {31'b0, rs1_busy}, 32'h1);
    chk("r5_robid", {28'b0, rs1_robid}, 32'h3);
    commit_en = 1; commit_index = 5; commit_robid = 3; commit_value = 32'hDEADBEEF; #1;
    chk("r5_bypass_val", rs1_value, 32'hDEADBEEF);
    chk("r5_bypass_busy", {31'b0, rs1_busy}, 32'h0);
    tick(); idle(); #1;
    chk("r5_after_val", rs1_value, 32'hDEADBEEF);
    chk("r5_after_busy", {31'b0, rs1_busy}, 32'h0);

    // double rename of r7; stale commit writes value only
    issue(7, 2);
    issue(7, 4);
    rs2_index = 7;
    commit_en = 1; commit_index = 7; commit_robid = 2; commit_value = 32'h11; #1;
    chk("r7_stale_nobypass", rs2_value, 32'h0);
    chk("r7_stale_busy_now", {31'b0, rs2_busy}, 32'h1);
    tick(); idle(); #1;
    chk("r7_stale_val", rs2_value, 32'h11);
    chk("r7_stale_busy", {31'b0, rs2_busy}, 32'h1);
    chk("r7_stale_robid", {28'b0, rs2_robid}, 32'h4);
    commit_en = 1; commit_index = 7; commit_robid = 4; commit_value = 32'h22; #1;
    chk("r7_bypass_val", rs2_value, 32'h22);
    tick(); idle(); #1;
    chk("r7_final_val", rs2_value, 32'h22);
    chk("r7_final_busy", {31'b0, rs2_busy}, 32'h0);

    // commit and issue on the same register in one cycle
    issue(9, 1);
    commit_en = 1; commit_index = 9; commit_robid = 1; commit_value = 32'h55;
    issue_en = 1; issue_dest = 9; issue_robid = 6;
    tick(); idle();
    rs1_index = 9; #1;
    chk("r9_val", rs1_value, 32'h55);
    chk("r9_busy", {31'b0, rs1_busy}, 32'h1);
    chk("r9_robid", {28'b0, rs1_robid}, 32'h6);

    // flush with concurrent commit and issue
    issue(3, 8);
    issue(4, 9);
    rs1_index = 3; rs2_index = 4; #1;
    chk("r3_busy_pre", {31'b0, rs1_busy}, 32'h1);
    flush = 1;
    commit_en = 1; commit_index = 3; commit_robid = 0; commit_value = 32'h77;
    issue_en = 1; issue_dest = 8; issue_robid = 5;
    tick(); idle(); #1;
    chk("flush_r3_busy", {31'b0, rs1_busy}, 32'h0);
    chk("flush_r3_val", rs1_value, 32'h77);
    chk("flush_r4_busy", {31'b0, rs2_busy}, 32'h0);
    rs1_index = 8; #1;
    chk("flush_r8_busy", {31'b0, rs1_busy}, 32'h0);
    rs1_index = 9; #1;
    chk("flush_r9_busy", {31'b0, rs1_busy}, 32'h0);

    // x0 writes and renames are ignored
    rs1_index = 0;
    commit_en = 1; commit_index = 0; commit_robid = 0; commit_value = 32'hFFFFFFFF;
    issue_en = 1; issue_dest = 0; issue_robid = 1;
    tick(); idle(); #1;
    chk("x0_val", rs1_value, 32'h0);
    chk("x0_busy", {31'b0, rs1_busy}, 32'h0);

    // rdy low freezes commit and issue; queries stay live
    rdy = 0;
    commit_en = 1; commit_index = 2; commit_robid = 0; commit_value = 32'h99;
    issue_en = 1; issue_dest = 11; issue_robid = 2;
    rs1_index = 5; #1;
    chk("frozen_query", rs1_value, 32'hDEADBEEF);
    tick(); idle(); rdy = 1;
    rs1_index = 2; rs2_index = 11; #1;
    chk("frozen_r2_val", rs1_value, 32'h0);
    chk("frozen_r11_busy", {31'b0, rs2_busy}, 32'h0);

    // reset mid-operation, with rdy low, discards renames and values
    issue(10, 7);
    rdy = 0; rst = 1;
    tick();
    rst = 0; rdy = 1;
    rs1_index = 10; rs2_index = 5; #1;
    chk("rst_r10_busy", {31'b0, rs1_busy}, 32'h0);
    chk("rst_r5_val", rs2_value, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter: ROB_LOG, default 4, ROB tag width (ROB holds 2^ROB_LOG entries).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 rdy  input  1  global ready; low freezes all state.
REQ-005 flush  input  1  misprediction/jump flush from commit stage.
REQ-006 commit_en  input  1  commit write request.
REQ-007 commit_index  input  5  architectural destination of commit.
REQ-008 commit_robid  input  ROB_LOG  ROB tag of committing instruction.
REQ-009 commit_value  input  32  result being committed.
REQ-010 issue_en  input  1  rename request from issue stage.
REQ-011 issue_dest  input  5  destination register of issuing instruction.
REQ-012 issue_robid  input  ROB_LOG  ROB tag allocated to issuing instruction.
REQ-013 rs1_index, rs2_index  input  5 each  source register queries.
REQ-014 rs1_value, rs2_value  output  32 each  architectural or forwarded value.
REQ-015 rs1_busy, rs2_busy  output  1 each  operand pending in ROB.
REQ-016 rs1_robid, rs2_robid  output  ROB_LOG each  producing ROB tag; valid only when busy=1.

Function
REQ-017 State: 32 x 32-bit value, 32 x busy bit, 32 x ROB_LOG-bit tag.
REQ-018 x0: value hard 0, busy never set; writes/renames to index 0 ignored.
REQ-019 rdy=0 (rst=0): no state change; query outputs still combinationally valid.
REQ-020 Commit (commit_en=1, index!=0): value[index] <= commit_value next edge, 1-cycle latency.
REQ-021 Commit clears busy[index] only if busy[index]=1 and tag[index]==commit_robid; stale-tag commit writes value, leaves busy/tag unchanged.
REQ-022 Issue (issue_en=1, dest!=0, flush=0): busy[dest] <= 1, tag[dest] <= issue_robid next edge; overwrites older pending tag.
REQ-023 Commit and issue same register same cycle: value written, busy stays 1, tag = issue_robid (issue wins).
REQ-024 Flush=1: all busy bits cleared next edge; commit in same cycle still writes value; issue in same cycle ignored.
REQ-025 Query combinational, per port: index 0 -> value 0, busy 0, robid 0.
REQ-026 Query, busy[idx]=0 -> value[idx], busy 0.
REQ-027 Query, busy[idx]=1 and commit_en=1 with commit_index==idx and commit_robid==tag[idx] -> value=commit_value, busy 0 (same-cycle bypass).
REQ-028 Query, busy[idx]=1 otherwise -> value=value[idx], busy 1, robid=tag[idx].
REQ-029 Query never reflects same-cycle issue; issue stage resolves self-dependency.
REQ-030 Tag compare is full ROB_LOG width; tag wrap-around needs no special handling (ROB never holds two live entries with same tag).

Reset
REQ-031 rst=1 at edge: all values 0, all busy 0, all tags 0; overrides rdy, flush, commit, issue.
REQ-032 Reset mid-operation: pending renames discarded; first post-reset query of any register returns value 0, busy 0.

Verification
REQ-033 Reset, issue_en dest=5 robid=3; next cycle query rs1=5 -> busy 1, robid 3; commit idx5 robid3 value 0xDEADBEEF same cycle -> rs1_value 0xDEADBEEF, busy 0; after edge busy 0, value held.
REQ-034 Issue dest=7 robid=2, then dest=7 robid=4; commit idx7 robid2 value 0x11 -> value[7]=0x11, rs2 query busy 1 robid 4; commit robid4 value 0x22 -> busy 0, value 0x22.
REQ-035 Same cycle commit idx9 robid1 value 0x55 (tag match) and issue dest9 robid6 -> after edge value 0x55, busy 1, robid 6.
REQ-036 Registers 3,4 busy; flush=1 with commit idx3 value 0x77 and issue dest8 robid5 -> after edge busy[3]=busy[4]=busy[8]=0, value[3]=0x77.
REQ-037 commit idx0 value 0xFFFFFFFF, issue dest0 -> query rs1=0 returns 0, busy 0; rdy=0 with commit idx2 value 0x99 -> value[2] unchanged.
